// File: rtl/pulse_ctrl_pkg.sv
// Shared encodings and default widths for the pulse measurement
// sequencer and its gate timer.
package pulse_ctrl_pkg;

    localparam int CNT_W_DEF  = 16;
    localparam int GATE_W_DEF = 32;
    localparam int GAP_DEF    = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GATE    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_HOLD    = 3'd3,
        ST_GAP     = 3'd4
    } pm_state_t;

endpackage

// File: rtl/pulse_gate_timer.sv
// Loadable down-counter; expire flags the last cycle of a window.
// Used for both the gate window and the inter-measurement gap.
module pulse_gate_timer #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_expire
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (i_load) begin
            cnt_q <= i_load_val;
        end else if (i_dec && cnt_q != '0) begin
            cnt_q <= cnt_q - ONE;
        end
    end

    assign o_expire = (cnt_q == ONE);

endmodule

// File: rtl/pulse_meas_ctrl.sv
// Measurement sequencer: opens a counter gate window, captures the
// final count with wrap detection and hands it over valid/ready.
module pulse_meas_ctrl
    import pulse_ctrl_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int GATE_W     = GATE_W_DEF,
    parameter int GAP_CYCLES = GAP_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_cont,
    input  logic              i_abort,
    input  logic [GATE_W-1:0] i_gate_len,
    input  logic [CNT_W-1:0]  i_pulse_cnt,
    output logic              o_cnt_en,
    output logic              o_busy,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [CNT_W-1:0]  o_result,
    output logic              o_overflow
);

    localparam logic [GATE_W-1:0] ONE = {{(GATE_W-1){1'b0}}, 1'b1};
    localparam int GAP_N = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam logic [GATE_W-1:0] GAP_LEN = GATE_W'(GAP_N);

    pm_state_t state_q;
    pm_state_t state_d;

    logic [GATE_W-1:0] len_q;
    logic              cont_q;
    logic              ovf_q;
    logic [CNT_W-1:0]  prev_cnt_q;

    logic              tmr_load;
    logic [GATE_W-1:0] tmr_val;
    logic              tmr_dec;
    logic              tmr_expire;

    logic [GATE_W-1:0] start_len;
    logic              cnt_drop;
    logic              abort_ok;
    logic              capture;
    logic              gate_entry;

    assign start_len  = (i_gate_len == '0) ? ONE : i_gate_len;
    assign cnt_drop   = (i_pulse_cnt < prev_cnt_q);
    assign abort_ok   = i_abort && (state_q != ST_IDLE);
    assign capture    = (state_q == ST_CAPTURE) && !abort_ok;
    assign gate_entry = (state_d == ST_GATE) && (state_q != ST_GATE);

    pulse_gate_timer #(
        .W (GATE_W)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (tmr_load),
        .i_load_val (tmr_val),
        .i_dec      (tmr_dec),
        .o_expire   (tmr_expire)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = len_q;
        tmr_dec  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d  = ST_GATE;
                    tmr_load = 1'b1;
                    tmr_val  = start_len;
                end
            end
            ST_GATE: begin
                tmr_dec = 1'b1;
                if (tmr_expire) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                // o_res_valid is high throughout HOLD
                if (i_res_ready) begin
                    if (cont_q && i_cont) begin
                        state_d  = ST_GAP;
                        tmr_load = 1'b1;
                        tmr_val  = GAP_LEN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                tmr_dec = 1'b1;
                if (tmr_expire) begin
                    state_d  = ST_GATE;
                    tmr_load = 1'b1;
                    tmr_val  = len_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort_ok) begin
            state_d  = ST_IDLE;
            tmr_load = 1'b0;
            tmr_dec  = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            len_q  <= ONE;
            cont_q <= 1'b0;
        end else if (state_q == ST_IDLE && i_start) begin
            len_q  <= start_len;
            cont_q <= i_cont;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            prev_cnt_q <= i_pulse_cnt;
            if (gate_entry) begin
                ovf_q <= 1'b0;
            end else if (state_q == ST_GATE && cnt_drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Outputs decode the next state so they line up with it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cnt_en    <= 1'b0;
            o_busy      <= 1'b0;
            o_res_valid <= 1'b0;
            o_result    <= '0;
            o_overflow  <= 1'b0;
        end else begin
            o_cnt_en    <= (state_d == ST_GATE);
            o_busy      <= (state_d != ST_IDLE);
            o_res_valid <= (state_d == ST_HOLD);
            if (capture) begin
                o_result   <= i_pulse_cnt;
                o_overflow <= ovf_q | cnt_drop;
            end
        end
    end

endmodule

// File: doc/pulse_meas_ctrl.md
Name: pulse_meas_ctrl

Overview:
Measurement sequencer for the pulse counter datapath. Drives the counter's enable to open a gate window of programmable length, then captures the final count. Detects counter wrap and hands the result to the host over a valid/ready interface. Supports single-shot and continuous (back-to-back) measurement; sits between the register/host interface and one pulse counter instance.

Parameters:
CNT_W, 16, width of the counter value and the result
GATE_W, 32, width of the gate-length field
GAP_CYCLES, 2, idle cycles with enable low between continuous measurements (min 1; guarantees the counter clears)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset, asynchronous, active-low
i_start  in  1  single-cycle start request
i_cont  in  1  continuous mode; sampled at start and at each result acceptance
i_abort  in  1  abandon the current measurement
i_gate_len  in  GATE_W  gate length in i_clk cycles, latched at start
i_pulse_cnt  in  CNT_W  count value from the pulse counter
o_cnt_en  out  1  enable to the pulse counter (low clears it)
o_busy  out  1  high in any state other than IDLE
o_res_valid  out  1  result available
i_res_ready  in  1  host accepts result
o_result  out  CNT_W  captured pulse count
o_overflow  out  1  counter wrapped during this gate; qualified by o_res_valid

Behaviour:
- Reset (async assert, sync release on i_clk): state IDLE; o_cnt_en=0, o_busy=0, o_res_valid=0, o_result=0, o_overflow=0; gate timer=0.
- All outputs are registered.
- IDLE:
  - i_start=1 -> latch len=max(i_gate_len,1), latch i_cont, load timer=len, go GATE.
  - i_start is ignored in every other state.
- GATE:
  - o_cnt_en=1 for exactly len cycles; the timer decrements each cycle; timer==1 -> CAPTURE.
  - Overflow: sticky flag set when i_pulse_cnt(t) < i_pulse_cnt(t-1) while in GATE; cleared at GATE entry.
- CAPTURE (1 cycle):
  - o_cnt_en=0. The counter still holds its final value, which includes any increment at the edge closing the gate.
  - Latch o_result=i_pulse_cnt; latch o_overflow from the sticky flag, also set if i_pulse_cnt < previous sample.
  - Go HOLD with o_res_valid=1.
- HOLD:
  - o_res_valid=1; o_result/o_overflow stable until handshake.
  - Handshake is valid&&ready in the same cycle. The following cycle o_res_valid=0.
  - On handshake: if latched cont=1 and i_cont=1, go GAP; otherwise go IDLE.
  - Continuous mode never drops or overwrites an unaccepted result; it stalls in HOLD.
- GAP:
  - o_cnt_en=0 for GAP_CYCLES cycles, then reload timer=len and go GATE. i_gate_len is not re-sampled.
- Abort, from GATE, CAPTURE, GAP or HOLD:
  - Next state IDLE, o_cnt_en=0, o_res_valid=0; no result is produced. o_result keeps its last value.
  - Abort has priority over the handshake and over timer expiry in the same cycle.
- Latency:
  - Start to first o_cnt_en=1: 1 cycle.
  - Final gate cycle to o_res_valid=1: 1 cycle (the CAPTURE cycle).
- Counter pipeline note: edges within about 2 cycles before gate close may fall into the next window or be lost. This is accepted and documented as ±1 count resolution.
- i_gate_len=0 behaves as 1. i_gate_len=2^GATE_W-1 must complete without timer wrap.

Decomposition:
- Shared package/include pulse_ctrl_pkg:
  - state encoding constants ST_IDLE, ST_GATE, ST_CAPTURE, ST_HOLD, ST_GAP.
  - default widths CNT_W/GATE_W.
- One sub-module, pulse_gate_timer: loadable down-counter (GATE_W) with load, dec and an expire flag at value 1. Reused for the GAP count.
- FSM and capture registers stay in pulse_meas_ctrl.

Test Plan:
- Single shot: gate_len=100, 25 input pulses of 2-cycle period-4 -> o_cnt_en high exactly 100 cycles; o_result=25, o_overflow=0; o_res_valid held until i_res_ready, then IDLE, o_busy=0.
- gate_len=0: o_cnt_en high exactly 1 cycle; result valid after 1 CAPTURE cycle, value 0 or 1 depending on edge phase.
- Overflow: CNT_W=16, gate_len=140000, a pulse every 2 cycles -> counter wraps; o_overflow=1, o_result=70000 mod 65536 (±1).
- Continuous: i_cont=1, gate_len=50, i_res_ready held low 20 cycles after valid -> stalls in HOLD with o_cnt_en=0; after ready, GAP=2 cycles low, next gate starts; three consecutive results match the stimulus counts.
- Abort mid-GATE at cycle 30 of 100 -> next cycle o_cnt_en=0, IDLE, no o_res_valid; an immediate new start runs normally. Abort and ready in the same HOLD cycle -> IDLE, no second measurement.
- Async reset asserted mid-GATE between clock edges -> o_cnt_en, o_busy and o_res_valid go 0 immediately; after release, no activity until i_start.
